// File: rtl/bcd_key_scheduler.sv
// Debounced ten-key front end that time-shares one external 10-to-4 BCD encoder
// and returns each encoded digit to a consumer over a valid/ready handshake.
module bcd_key_scheduler #(
    parameter int DB_CYCLES = 4,
    parameter int DBW       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  key,
    output logic        enc_en,
    output logic [9:0]  enc_cin,
    input  logic [3:0]  enc_cout,
    output logic [3:0]  code,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        code_err,
    output logic        overrun,
    output logic [9:0]  pending
);

    localparam int             NKEYS    = 10;
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [3:0]     LAST_KEY = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        HOLD
    } state_t;

    state_t           state;
    logic [NKEYS-1:0] key_s1;
    logic [NKEYS-1:0] key_s2;
    logic [NKEYS-1:0] db_state;
    logic [DBW-1:0]   db_cnt [NKEYS];
    logic [NKEYS-1:0] press_evt;
    logic [NKEYS-1:0] grant_clr;
    logic [3:0]       last_grant;
    logic [3:0]       rr_pick;
    logic             rr_found;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v);
        return (v >= LAST_KEY) ? 4'd0 : v + 4'd1;
    endfunction

    // Two-flop synchroniser for the asynchronous key lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1 <= '0;
            key_s2 <= '0;
        end else begin
            // NOTE: non-blocking so key_s2 receives the previous key_s1, giving two real flop stages.
            key_s1 <= key;
            key_s2 <= key_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_state <= '0;
            // NOTE: the counter array is cleared element by element because the debounce timing depends on every counter starting at zero.
            for (int i = 0; i < NKEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                if (key_s2[i] == db_state[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_state[i] <= key_s2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is the cycle in which a 0->1 debounced flip is committed.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a value up front so no latch is inferred.
        press_evt = '0;
        for (int i = 0; i < NKEYS; i++) begin
            press_evt[i] = key_s2[i] && !db_state[i] && (db_cnt[i] == DB_LAST);
        end
    end

    assign grant_clr = (state == ENCODE) ? (10'd1 << last_grant) : '0;

    // A clear and a new press on the same bit leave it set without flagging an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            pending <= (pending & ~grant_clr) | press_evt;
            overrun <= |(press_evt & pending & ~grant_clr);
        end
    end

    always_comb begin
        logic [3:0] idx;
        rr_pick  = '0;
        rr_found = 1'b0;
        idx      = wrap_inc(last_grant);
        for (int k = 0; k < NKEYS; k++) begin
            if (!rr_found && pending[idx]) begin
                rr_pick  = idx;
                rr_found = 1'b1;
            end
            idx = wrap_inc(idx);
        end
    end

    // last_grant doubles as the key being encoded while in ENCODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            enc_en     <= 1'b0;
            enc_cin    <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            code_err   <= 1'b0;
            last_grant <= LAST_KEY;
        end else begin
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        enc_en     <= 1'b1;
                        enc_cin    <= 10'd1 << rr_pick;
                        last_grant <= rr_pick;
                        state      <= ENCODE;
                    end
                end
                ENCODE: begin
                    code       <= enc_cout;
                    code_err   <= (enc_cout != last_grant);
                    code_valid <= 1'b1;
                    enc_en     <= 1'b0;
                    enc_cin    <= '0;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (code_ready) begin
                        code_valid <= 1'b0;
                        code_err   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_key_scheduler.sv
// Directed bench for bcd_key_scheduler with a behavioural 10-to-4 encoder
// that can be made to return a wrong digit for key 6.
module tb_bcd_key_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] key;
    logic       enc_en;
    logic [9:0] enc_cin;
    logic [3:0] enc_cout;
    logic [3:0] code;
    logic       code_valid;
    logic       code_ready;
    logic       code_err;
    logic       overrun;
    logic [9:0] pending;
    logic       fault_en;

    int errors = 0;
    int checks = 0;

    logic [3:0] seen_code [16];
    logic       seen_err  [16];
    logic [9:0] seen_pend [16];
    int         seen_t    [16];
    int         seen_n;
    logic [9:0] first_cin;
    logic       cin_rec;

    always #5 clk = ~clk;

    bcd_key_scheduler #(.DB_CYCLES(4), .DBW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .enc_en     (enc_en),
        .enc_cin    (enc_cin),
        .enc_cout   (enc_cout),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_err   (code_err),
        .overrun    (overrun),
        .pending    (pending)
    );

    // External encoder: index of the set bit, or 12 for key 6 when faulted.
    always_comb begin
        enc_cout = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (enc_cin[i]) enc_cout = 4'(i);
        end
        if (fault_en && enc_en && enc_cin[6]) enc_cout = 4'd12;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Gathers up to n codes (code_ready assumed high) within a cycle budget.
    task automatic collect(input int n, input int budget);
        seen_n  = 0;
        cin_rec = 1'b0;
        first_cin = '0;
        for (int c = 0; c < budget && seen_n < n; c++) begin
            tick();
            if (enc_en && !cin_rec) begin
                first_cin = enc_cin;
                cin_rec   = 1'b1;
            end
            if (code_valid) begin
                seen_code[seen_n] = code;
                seen_err[seen_n]  = code_err;
                seen_pend[seen_n] = pending;
                seen_t[seen_n]    = c;
                seen_n++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key = 10'h3FF; code_ready = 1'b0; fault_en = 1'b0;
        settle(3);
        checks++; if (enc_en !== 1'b0) begin errors++; $display("FAIL rst_enc_en: got %0h expected 0", enc_en); end
        checks++; if (enc_cin !== 10'h000) begin errors++; $display("FAIL rst_enc_cin: got %0h expected 0", enc_cin); end
        checks++; if (code !== 4'd0) begin errors++; $display("FAIL rst_code: got %0h expected 0", code); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL rst_code_valid: got %0h expected 0", code_valid); end
        checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL rst_code_err: got %0h expected 0", code_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %0h expected 0", overrun); end
        checks++; if (pending !== 10'h000) begin errors++; $display("FAIL rst_pending: got %0h expected 0", pending); end
        rst = 1'b0; code_ready = 1'b1;
        collect(10, 80);
        checks++; if (first_cin !== 10'h001) begin errors++; $display("FAIL rst_first_grant: got %0h expected 001", first_cin); end
        checks++; if (seen_n !== 10) begin errors++; $display("FAIL rst_drain_count: got %0d expected 10", seen_n); end
        for (int i = 0; i < seen_n; i++) begin
            checks++; if (seen_code[i] !== 4'(i)) begin errors++; $display("FAIL rr_all_code[%0d]: got %0d expected %0d", i, seen_code[i], i); end
            if (i > 0) begin
                checks++; if (seen_t[i] - seen_t[i-1] !== 3) begin errors++; $display("FAIL rr_all_spacing[%0d]: got %0d expected 3", i, seen_t[i] - seen_t[i-1]); end
            end
        end
        key = 10'h000;
        settle(12);
    endtask

    task automatic test_round_robin();
        key = 10'b10_1000_0010;
        collect(3, 40);
        checks++; if (seen_n !== 3) begin errors++; $display("FAIL rr3_count: got %0d expected 3", seen_n); end
        checks++; if (seen_code[0] !== 4'd1) begin errors++; $display("FAIL rr3_first: got %0d expected 1", seen_code[0]); end
        checks++; if (seen_code[1] !== 4'd7) begin errors++; $display("FAIL rr3_second: got %0d expected 7", seen_code[1]); end
        checks++; if (seen_code[2] !== 4'd9) begin errors++; $display("FAIL rr3_third: got %0d expected 9", seen_code[2]); end
        key = 10'h000;
        settle(12);
        key = 10'b00_1000_0001;
        collect(2, 40);
        checks++; if (seen_n !== 2) begin errors++; $display("FAIL rr_wrap_count: got %0d expected 2", seen_n); end
        checks++; if (seen_code[0] !== 4'd0) begin errors++; $display("FAIL rr_wrap_first: got %0d expected 0", seen_code[0]); end
        checks++; if (seen_code[1] !== 4'd7) begin errors++; $display("FAIL rr_wrap_second: got %0d expected 7", seen_code[1]); end
        key = 10'h000;
        settle(12);
    endtask

    task automatic test_single_key();
        int extra;
        key = 10'b00_0000_1000;
        settle(5);
        checks++; if (pending !== 10'h000) begin errors++; $display("FAIL single_early_pending: got %0h expected 0", pending); end
        tick();
        checks++; if (pending !== 10'h008) begin errors++; $display("FAIL single_pending: got %0h expected 008", pending); end
        checks++; if (enc_en !== 1'b0) begin errors++; $display("FAIL single_early_en: got %0h expected 0", enc_en); end
        tick();
        checks++; if (enc_en !== 1'b1) begin errors++; $display("FAIL single_enc_en: got %0h expected 1", enc_en); end
        checks++; if (enc_cin !== 10'h008) begin errors++; $display("FAIL single_enc_cin: got %0h expected 008", enc_cin); end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0h expected 0", code_valid); end
        tick();
        checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0h expected 1", code_valid); end
        checks++; if (code !== 4'd3) begin errors++; $display("FAIL single_code: got %0d expected 3", code); end
        checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL single_err: got %0h expected 0", code_err); end
        checks++; if (pending !== 10'h000) begin errors++; $display("FAIL single_cleared: got %0h expected 0", pending); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (code_valid || enc_en) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL single_held_repeat: got %0d expected 0", extra); end
        key = 10'h000;
        settle(12);
    endtask

    task automatic test_bounce();
        int noise;
        noise = 0;
        for (int p = 0; p < 5; p++) begin
            key = 10'h020;
            for (int i = 0; i < 2; i++) begin tick(); if (pending != 0 || code_valid) noise++; end
            key = 10'h000;
            for (int i = 0; i < 2; i++) begin tick(); if (pending != 0 || code_valid) noise++; end
        end
        checks++; if (noise !== 0) begin errors++; $display("FAIL bounce_noise: got %0d expected 0", noise); end
        key = 10'h020;
        collect(1, 30);
        checks++; if (seen_n !== 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", seen_n); end
        checks++; if (seen_code[0] !== 4'd5) begin errors++; $display("FAIL bounce_code: got %0d expected 5", seen_code[0]); end
        collect(1, 15);
        checks++; if (seen_n !== 0) begin errors++; $display("FAIL bounce_repeat: got %0d expected 0", seen_n); end
        key = 10'h000;
        settle(12);
    endtask

    task automatic test_backpressure();
        int unstable;
        int ovr;
        code_ready = 1'b0;
        key = 10'h004;
        for (int n = 0; n < 30 && !code_valid; n++) tick();
        checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %0h expected 1", code_valid); end
        checks++; if (code !== 4'd2) begin errors++; $display("FAIL bp_code: got %0d expected 2", code); end
        unstable = 0;
        ovr = 0;
        for (int w = 0; w < 4; w++) begin
            key = (w == 0 || w == 2) ? 10'h010 : 10'h000;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (code_valid !== 1'b1 || code !== 4'd2 || code_err !== 1'b0) unstable++;
                if (overrun) ovr++;
            end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
        checks++; if (ovr !== 1) begin errors++; $display("FAIL bp_overrun: got %0d pulses expected 1", ovr); end
        checks++; if (pending !== 10'h010) begin errors++; $display("FAIL bp_pending: got %0h expected 010", pending); end
        code_ready = 1'b1;
        tick();
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL bp_handshake: got %0h expected 0", code_valid); end
        collect(1, 20);
        checks++; if (seen_code[0] !== 4'd4 || seen_n !== 1) begin errors++; $display("FAIL bp_code4: got %0d (n=%0d) expected 4", seen_code[0], seen_n); end
        collect(1, 15);
        checks++; if (seen_n !== 0) begin errors++; $display("FAIL bp_single4: got %0d extra expected 0", seen_n); end
        settle(4);
    endtask

    task automatic test_fault();
        fault_en = 1'b1;
        key = 10'h040;
        collect(1, 30);
        checks++; if (first_cin !== 10'h040) begin errors++; $display("FAIL fault_cin: got %0h expected 040", first_cin); end
        checks++; if (seen_code[0] !== 4'd12 || seen_n !== 1) begin errors++; $display("FAIL fault_code: got %0d (n=%0d) expected 12", seen_code[0], seen_n); end
        checks++; if (seen_err[0] !== 1'b1) begin errors++; $display("FAIL fault_err: got %0h expected 1", seen_err[0]); end
        checks++; if (seen_pend[0] !== 10'h000) begin errors++; $display("FAIL fault_pending: got %0h expected 0", seen_pend[0]); end
        tick();
        checks++; if (code_err !== 1'b0 || code_valid !== 1'b0) begin errors++; $display("FAIL fault_drop: got err=%0h valid=%0h expected 0 0", code_err, code_valid); end
        key = 10'h000;
        fault_en = 1'b0;
        settle(12);
    endtask

    task automatic test_reset_mid();
        code_ready = 1'b0;
        key = 10'h100;
        for (int n = 0; n < 30 && !code_valid; n++) tick();
        checks++; if (code_valid !== 1'b1 || code !== 4'd8) begin errors++; $display("FAIL mid_setup: got valid=%0h code=%0d expected 1 8", code_valid, code); end
        key = 10'h102;
        for (int n = 0; n < 20 && !pending[1]; n++) tick();
        checks++; if (pending !== 10'h002) begin errors++; $display("FAIL mid_pending: got %0h expected 002", pending); end
        rst = 1'b1;
        key = 10'h000;
        tick();
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0h expected 0", code_valid); end
        checks++; if (pending !== 10'h000) begin errors++; $display("FAIL mid_clear: got %0h expected 0", pending); end
        rst = 1'b0;
        code_ready = 1'b1;
        settle(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single_key();
        test_bounce();
        test_backpressure();
        test_fault();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_key_scheduler.md
Name: bcd_key_scheduler

Overview:
- Front-end controller for the shared 10-to-4 `bcd_encoder` in the decimal key-input path.
- Debounces ten raw key lines and queues each debounced press as a pending request.
- Grants pending keys round-robin, one at a time, to the single external encoder by driving its enable and one-hot input.
- Returns the encoded BCD digit to the consumer over a valid/ready handshake.

Parameters:
- DB_CYCLES, 4: consecutive stable cycles required to accept a press or a release (range 1..255).
- DBW, 8: width of each per-key debounce counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- key  input  10  raw key lines, 1 = pressed; key[i] is digit i; asynchronous, synchronised internally by 2 flops.
- enc_en  output  1  enable to the encoder.
- enc_cin  output  10  one-hot input to the encoder.
- enc_cout  input  4  combinational BCD result from the encoder.
- code  output  4  captured BCD digit.
- code_valid  output  1  code is valid.
- code_ready  input  1  consumer accepts code.
- code_err  output  1  encoder result mismatch, valid with code_valid.
- overrun  output  1  one-cycle pulse: a press was lost.
- pending  output  10  queued requests, for debug.

Behaviour:
- **Reset.** All outputs 0, all debounce counters 0, debounced state 0, sync flops 0, FSM in IDLE, last_grant = 9 so the first search starts at key 0. Reset mid-handshake drops code_valid and clears all pending requests at the next edge.
- **Debounce, per key:**
  - Compare the synchronised key with the debounced state. On mismatch, increment the counter; on match, clear it.
  - When the counter reaches DB_CYCLES-1 while still mismatched, flip the debounced state and clear the counter.
  - A 0→1 flip is a press event, one cycle wide. A held key produces no further events until a debounced release.
  - Raw key high at cycle t gives a press event at t+2+DB_CYCLES-1 (2 sync cycles, DB_CYCLES-1 counting cycles).
- **Pending register:**
  - A press event sets pending[i].
  - If pending[i] is already 1 and not being cleared that cycle, the event is dropped and overrun pulses for 1 cycle.
  - Event and clear of the same bit in the same cycle: the bit stays 1, no overrun.
- **FSM: IDLE, ENCODE, HOLD.**
  - **IDLE.** If pending != 0, select g = first set bit scanning last_grant+1, last_grant+2, … modulo 10. Register enc_en = 1 and enc_cin = one-hot(g), set last_grant = g, go to ENCODE. If pending == 0, stay; enc_en = 0, enc_cin = 0.
  - **ENCODE (one cycle).**
    - Capture code = enc_cout.
    - code_err = (enc_cout != g); this also catches enc_cout > 9.
    - Set code_valid = 1, clear pending[g], deassert enc_en and enc_cin, go to HOLD.
  - **HOLD.** code, code_err and code_valid are held stable. When code_valid && code_ready, deassert code_valid and code_err next cycle and return to IDLE.
  - No grant is issued while in HOLD, so there is at most one outstanding code.
  - Earliest next grant is the cycle after the handshake.
- **Latency.** pending set at edge t → enc_en high during t+1 → code_valid high from t+2. Minimum per-key throughput is 3 cycles with code_ready held high.
- **enc_en timing.** enc_en is never high outside ENCODE, and enc_cin is always one-hot or zero.
- **Fairness.** Round-robin ensures that with all 10 keys pending, every key is granted within 10 grants.
- **Counter width.** Counters saturate at DB_CYCLES-1. DBW must satisfy 2^DBW > DB_CYCLES.

Test Plan:
- **Reset.** Assert rst for 3 cycles with key = 10'h3FF → all outputs 0. After release, the first grant is key 0.
- **Single key.** key = 10'b0000001000 for 10 cycles, code_ready = 1 → one code_valid pulse with code = 4'd3, code_err = 0, enc_cin = 10'b0000001000 during ENCODE. No second code while the key is held.
- **Bounce.** key[5] toggles every 2 cycles for 20 cycles, then stays high (DB_CYCLES = 4) → no event during toggling; exactly one code = 5 after it settles.
- **Simultaneous keys, round-robin.**
  - key[1], key[7] and key[9] pressed in the same cycle → codes 1, 7, 9 in that order.
  - Then press key[0] and key[7] together → codes 0, 7 (last_grant = 9 wraps to 0).
- **Backpressure and overrun.**
  - Hold code_ready = 0 with code = 2 outstanding → code stays stable.
  - Press, release and re-press key[4] twice → the second press pulses overrun once; after code_ready = 1, only one code = 4 follows.
- **Encoder fault.** Force enc_cout = 4'd12 during ENCODE for grant 6 → code = 12, code_err = 1. Pending bit 6 is cleared.
